// File: rtl/fp_align_unit.sv
// Pre-add alignment: orders two unpacked operands by exponent and right-shifts the smaller mantissa
// SHIFT_STEP bits per cycle, collecting guard/round/sticky. Latency max(1, ceil(min(diff,26)/SHIFT_STEP)); enable=0 freezes all state.
module fp_align_unit #(
    parameter int SHIFT_STEP = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        enable,
    input  logic        start,
    output logic        ready,
    input  logic [7:0]  exp_a,
    input  logic [7:0]  exp_b,
    input  logic [23:0] mant_a,
    input  logic [23:0] mant_b,
    output logic        done,
    output logic        swapped,
    output logic [7:0]  aligned_exponent,
    output logic [23:0] mant_large,
    output logic [23:0] mant_small,
    output logic        guard,
    output logic        round,
    output logic        sticky
);
    localparam int         MAX_SHIFT = 26;
    localparam logic [4:0] STEP      = 5'(SHIFT_STEP);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [4:0]    rem_q, rem_d;
    logic [25:0]   wk_q, wk_d;          // {mantissa, guard, round}
    logic          wk_s_q, wk_s_d;
    logic          swapped_q, swapped_d;
    logic [7:0]    aexp_q, aexp_d;
    logic [23:0]   mlarge_q, mlarge_d;
    logic [23:0]   msmall_q, msmall_d;
    logic          guard_q, guard_d;
    logic          round_q, round_d;
    logic          sticky_q, sticky_d;

    logic          b_gt;
    logic [8:0]    diff9;
    logic [4:0]    rem0;
    logic [4:0]    step_k;
    logic [25:0]   shifted;
    logic [25:0]   lost;
    logic          new_s;

    assign b_gt    = (exp_b > exp_a);
    assign diff9   = b_gt ? ({1'b0, exp_b} - {1'b0, exp_a}) : ({1'b0, exp_a} - {1'b0, exp_b});
    assign rem0    = (diff9 >= 9'(MAX_SHIFT)) ? 5'(MAX_SHIFT) : diff9[4:0];
    assign step_k  = (rem_q > STEP) ? STEP : rem_q;
    assign shifted = wk_q >> step_k;
    // Everything that falls off below the round position accumulates into sticky.
    assign lost    = wk_q & ((26'd1 << step_k) - 26'd1);
    assign new_s   = wk_s_q | (|lost);

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        wk_d      = wk_q;
        wk_s_d    = wk_s_q;
        swapped_d = swapped_q;
        aexp_d    = aexp_q;
        mlarge_d  = mlarge_q;
        msmall_d  = msmall_q;
        guard_d   = guard_q;
        round_d   = round_q;
        sticky_d  = sticky_q;
        if (enable) begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        swapped_d = b_gt;
                        aexp_d    = b_gt ? exp_b : exp_a;
                        mlarge_d  = b_gt ? mant_b : mant_a;
                        wk_d      = {(b_gt ? mant_a : mant_b), 2'b00};
                        wk_s_d    = 1'b0;
                        rem_d     = rem0;
                        state_d   = S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    rem_d  = rem_q - step_k;
                    wk_d   = shifted;
                    wk_s_d = new_s;
                    if (rem_q == step_k) begin
                        state_d  = S_DONE;
                        msmall_d = shifted[25:2];
                        guard_d  = shifted[1];
                        round_d  = shifted[0];
                        sticky_d = new_s;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            rem_q     <= '0;
            wk_q      <= '0;
            wk_s_q    <= 1'b0;
            swapped_q <= 1'b0;
            aexp_q    <= '0;
            mlarge_q  <= '0;
            msmall_q  <= '0;
            guard_q   <= 1'b0;
            round_q   <= 1'b0;
            sticky_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            wk_q      <= wk_d;
            wk_s_q    <= wk_s_d;
            swapped_q <= swapped_d;
            aexp_q    <= aexp_d;
            mlarge_q  <= mlarge_d;
            msmall_q  <= msmall_d;
            guard_q   <= guard_d;
            round_q   <= round_d;
            sticky_q  <= sticky_d;
        end
    end

    assign ready            = (state_q == S_IDLE);
    assign done             = (state_q == S_DONE);
    assign swapped          = swapped_q;
    assign aligned_exponent = aexp_q;
    assign mant_large       = mlarge_q;
    assign mant_small       = msmall_q;
    assign guard            = guard_q;
    assign round            = round_q;
    assign sticky           = sticky_q;
endmodule

// File: tb/tb_fp_align_unit.sv
// Bench for fp_align_unit: directed literal cases plus randomized traffic against a latency/arithmetic model.
module tb_fp_align_unit;
    localparam int STEP = 4;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        enable = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  exp_a = '0, exp_b = '0;
    logic [23:0] mant_a = '0, mant_b = '0;
    logic        ready, done, swapped, guard, round, sticky;
    logic [7:0]  aligned_exponent;
    logic [23:0] mant_large, mant_small;

    int errors = 0;
    int checks = 0;

    fp_align_unit #(.SHIFT_STEP(STEP)) dut (
        .Clk(Clk), .Reset(Reset), .enable(enable), .start(start), .ready(ready),
        .exp_a(exp_a), .exp_b(exp_b), .mant_a(mant_a), .mant_b(mant_b),
        .done(done), .swapped(swapped), .aligned_exponent(aligned_exponent),
        .mant_large(mant_large), .mant_small(mant_small),
        .guard(guard), .round(round), .sticky(sticky)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: 0 idle, 1 busy, 2 done
    int          m_state = 0;
    int          m_cnt = 0;
    logic        m_swp = 0;
    logic [7:0]  m_exp = 0;
    logic [23:0] m_large = 0, m_small = 0, p_small = 0;
    logic        m_g = 0, m_r = 0, m_s = 0, p_g = 0, p_r = 0, p_s = 0;

    task automatic model_accept();
        int          d;
        logic [63:0] v;
        logic [23:0] sm;
        m_swp   = (exp_b > exp_a);
        m_exp   = m_swp ? exp_b : exp_a;
        m_large = m_swp ? mant_b : mant_a;
        sm      = m_swp ? mant_a : mant_b;
        d       = m_swp ? (int'(exp_b) - int'(exp_a)) : (int'(exp_a) - int'(exp_b));
        if (d > 26) d = 26;
        v       = {sm, 40'd0} >> d;
        p_small = v[63:40];
        p_g     = v[39];
        p_r     = v[38];
        p_s     = |v[37:0];
        m_cnt   = (d == 0) ? 1 : (d + STEP - 1) / STEP;
        m_state = 1;
    endtask

    initial begin
        forever begin
            @(posedge Clk);
            if (Reset) begin
                m_state = 0; m_swp = 0; m_exp = 0; m_large = 0; m_small = 0;
                m_g = 0; m_r = 0; m_s = 0;
            end else if (enable) begin
                if (m_state == 0) begin
                    if (start) model_accept();
                end else if (m_state == 1) begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        m_state = 2;
                        m_small = p_small; m_g = p_g; m_r = p_r; m_s = p_s;
                    end
                end else begin
                    m_state = 0;
                end
            end
            @(negedge Clk);
            chk("ready", 32'(ready), 32'(m_state == 0));
            chk("done", 32'(done), 32'(m_state == 2));
            chk("swapped", 32'(swapped), 32'(m_swp));
            chk("aligned_exponent", 32'(aligned_exponent), 32'(m_exp));
            chk("mant_large", 32'(mant_large), 32'(m_large));
            if (m_state != 1) begin
                chk("mant_small", 32'(mant_small), 32'(m_small));
                chk("grs", 32'({guard, round, sticky}), 32'({m_g, m_r, m_s}));
            end
        end
    end

    task automatic run_op(input logic [7:0] ea, input logic [23:0] ma, input logic [7:0] eb,
                          input logic [23:0] mb, input int stall_at, input int busy_at, output int lat);
        int w;
        int c;
        w = 0;
        while (!ready && w < 100) begin
            @(negedge Clk);
            w++;
        end
        if (!ready) chk("ready_timeout", 32'(ready), 32'd1);
        exp_a = ea; mant_a = ma; exp_b = eb; mant_b = mb; start = 1'b1;
        c = 0;
        lat = -1;
        while (c < 100) begin
            @(negedge Clk);
            c++;
            start = (busy_at != 0 && c == busy_at);
            if (stall_at != 0 && c == stall_at) enable = 1'b0;
            if (stall_at != 0 && c == stall_at + 5) enable = 1'b1;
            if (done) begin
                lat = c - 1;
                break;
            end
        end
        start = 1'b0;
        enable = 1'b1;
        if (lat < 0) chk("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic count_done(input int n, output int hits);
        hits = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            if (done) hits++;
        end
    endtask

    initial begin
        int lat;
        int hits;
        logic [7:0] ea, eb;

        repeat (2) @(negedge Clk);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_outs", 32'({swapped, aligned_exponent, guard, round, sticky}), 32'd0);
        chk("rst_mant", 32'(mant_small | mant_large), 32'd0);
        Reset = 1'b0;
        @(negedge Clk);

        run_op(8'd127, 24'h800000, 8'd127, 24'hC00000, 0, 0, lat);
        chk("eq_lat", 32'(lat), 32'd1);
        chk("eq_swp", 32'(swapped), 32'd0);
        chk("eq_small", 32'(mant_small), 32'hC00000);
        chk("eq_grs", 32'({guard, round, sticky}), 32'd0);

        run_op(8'd130, 24'h800000, 8'd127, 24'hC00001, 0, 0, lat);
        chk("small_lat", 32'(lat), 32'd1);
        chk("small_exp", 32'(aligned_exponent), 32'd130);
        chk("small_mant", 32'(mant_small), 32'h180000);
        chk("small_grs", 32'({swapped, guard, round, sticky}), 32'b0001);

        run_op(8'd100, 24'hFFFFFF, 8'd110, 24'h800000, 0, 2, lat);
        chk("swap_lat", 32'(lat), 32'd3);
        chk("swap_flag", 32'(swapped), 32'd1);
        chk("swap_exp", 32'(aligned_exponent), 32'd110);
        chk("swap_large", 32'(mant_large), 32'h800000);
        chk("swap_mant", 32'(mant_small), 32'h003FFF);
        chk("swap_grs", 32'({guard, round, sticky}), 32'b111);
        count_done(10, hits);
        chk("busy_start_no_second_done", 32'(hits), 32'd0);

        run_op(8'd127, 24'h800000, 8'd97, 24'hFFFFFF, 0, 0, lat);
        chk("sat_lat", 32'(lat), 32'd7);
        chk("sat_mant", 32'(mant_small), 32'd0);
        chk("sat_grs", 32'({guard, round, sticky}), 32'b001);

        run_op(8'd127, 24'h800000, 8'd97, 24'hFFFFFF, 3, 0, lat);
        chk("stall_lat", 32'(lat), 32'd12);
        chk("stall_mant", 32'(mant_small), 32'd0);

        exp_a = 8'd127; mant_a = 24'h800000; exp_b = 8'd97; mant_b = 24'hFFFFFF; start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        chk("mid_rst_ready", 32'(ready), 32'd1);
        chk("mid_rst_outs", 32'({done, swapped, aligned_exponent, guard, round, sticky}), 32'd0);
        chk("mid_rst_mant", 32'(mant_small | mant_large), 32'd0);
        count_done(10, hits);
        chk("mid_rst_no_done", 32'(hits), 32'd0);
        run_op(8'd130, 24'h800000, 8'd127, 24'hC00001, 0, 0, lat);
        chk("post_rst_lat", 32'(lat), 32'd1);
        chk("post_rst_mant", 32'(mant_small), 32'h180000);

        for (int i = 0; i < 4000; i++) begin
            @(negedge Clk);
            ea = 8'($urandom);
            eb = ($urandom_range(0, 3) == 0) ? 8'($urandom) : ea + 8'($urandom_range(0, 32)) - 8'd16;
            exp_a  = ea;
            exp_b  = eb;
            mant_a = 24'($urandom);
            mant_b = 24'($urandom);
            enable = ($urandom_range(0, 9) != 0);
            start  = ($urandom_range(0, 2) == 0);
            Reset  = ($urandom_range(0, 399) == 0);
        end
        @(negedge Clk);
        Reset = 1'b0; enable = 1'b1; start = 1'b0;
        repeat (40) @(negedge Clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
